sequencer_scheduler: RTL and testbench
======================================

Name: sequencer_scheduler

Overview:
Step-pattern controller for the sequencer datapath. It stores an STEPS-entry pattern of 4-bit notes and advances a step pointer on each tempo beat_pulse. On each step it drives the stored note for a fixed gate time. It also records live keypad notes into the pattern (overdub) and arbitrates the single note output between the live keypad and the pattern, with live notes taking priority.

Parameters:
STEPS, 8, number of pattern steps (power of two; pointer width is clog2(STEPS))
NOTE_W, 4, note code width; code 0 means silence
GATE_TICKS, 1500, clk cycles a step note sounds after its step starts (150 ms at 10 kHz); must be >= 1

Ports:
clk  input  1  system clock (10 kHz)
n_rst  input  1  asynchronous active-low reset
beat_pulse  input  1  one-cycle tempo tick from the sequencer clock divider
run  input  1  level; 1 = transport running
record  input  1  level; 1 = overdub live notes into pattern (effective only while run=1)
clear  input  1  one-cycle pulse; erase whole pattern
live_note  input  NOTE_W  current keypad note, 0 = no key
note_out  output  NOTE_W  registered arbitrated note
note_src  output  1  1 = note_out comes from pattern, 0 = live or silence
step  output  clog2(STEPS)  current step pointer (feeds beat LED decoder)
busy  output  1  high while the pattern is being cleared

Behaviour:
- One clock, clk. Reset is asynchronous, active-low on n_rst. All flops reset immediately when n_rst=0.
- Reset values: state=IDLE, step=0, every pattern entry=0, gate_cnt=0, live_prev=0, note_out=0, note_src=0, busy=0.
- States: IDLE, PLAY, RECORD, CLEAR. Next-state priority: clear > run/record decode.
  - clear=1 in any state -> CLEAR.
  - Otherwise run=0 -> IDLE; run=1, record=0 -> PLAY; run=1, record=1 -> RECORD.
- CLEAR:
  - Writes 0 to one entry per cycle, index 0..STEPS-1. Takes exactly STEPS cycles, then goes to IDLE.
  - busy=1 throughout. run, record, beat_pulse, further clear pulses and live_note are ignored; note_out=0.
  - step and gate_cnt are forced to 0.
- IDLE:
  - step is held and beat_pulse is ignored; gate_cnt=0.
- Entry from IDLE to PLAY or RECORD: in the entry cycle, gate_cnt loads GATE_TICKS if pattern[step]!=0.
- PLAY and RECORD, on beat_pulse:
  - step <= step+1, wrapping STEPS-1 -> 0.
  - gate_cnt <= GATE_TICKS if pattern[new step]!=0, else 0. This retriggers even when a gate is still active.
- With no beat_pulse, gate_cnt decrements by 1 each cycle while nonzero and saturates at 0.
- RECORD only, live_note rising edge (live_prev==0 and live_note!=0): pattern[step] <= live_note.
  - If this coincides with beat_pulse, the write goes to the pre-increment step.
  - Holding a key never re-writes. Changing from one nonzero note to another is not an edge.
- live_prev <= live_note every cycle, in all states except CLEAR (forced 0 there).
- Output arbitration, registered with 1-cycle latency:
  - If state!=CLEAR and live_note!=0: note_out=live_note, note_src=0.
  - Else if state is PLAY or RECORD and gate_cnt!=0: note_out=pattern[step], note_src=1.
  - Else: note_out=0, note_src=0.
- Leaving PLAY or RECORD for IDLE: gate_cnt=0 that cycle; pattern output stops on the following note_out update; step is retained.
- An entry written in the current step while its gate is active appears on note_out the next cycle. A write of a nonzero note does not load the gate.

Decomposition:
- Package sequencer_pkg holds:
  - localparams STEPS and NOTE_W;
  - typedef note_t (logic [NOTE_W-1:0]);
  - typedef step_t;
  - enum sched_state_t {IDLE, PLAY, RECORD, CLEAR}.
- One sub-module, step_gate_timer, contains the GATE_TICKS load/decrement/saturate counter. Its ports are load, clr and active.

Test Plan:
- Reset mid-RECORD with pattern {3,0,5,...}, then n_rst=0 -> note_out=0, step=0, all entries 0 while reset is asserted.
- GATE_TICKS=4; pattern[1]=7; run=1; beat_pulse once -> step=1, note_out=7 and note_src=1 for exactly 4 cycles, then 0.
- STEPS=8, run=1, 8 beat_pulses -> step goes 1..7 then wraps to 0.
- run=1, record=1 at step=2; live_note 0->9 on the same cycle as beat_pulse -> pattern[2]=9 and step=3; on the next lap, step 2 plays 9.
- Pattern gate active with note 5 while live_note=4 is held -> note_out=4, note_src=0; on key release -> note_out=5 if the gate is still active.
- clear pulse during PLAY -> busy=1 for 8 cycles, beat_pulse ignored, then IDLE with all entries 0 and step=0.

Source files
------------

// File: rtl/sequencer_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// sequencer_pkg
//   Shared types and sizes for the step-pattern scheduler.
//   STEPS  : number of pattern steps (power of two, so the pointer wraps freely)
//   NOTE_W : note code width, code 0 is silence
// -----------------------------------------------------------------------------
package sequencer_pkg;

  localparam int STEPS  = 8;
  localparam int NOTE_W = 4;
  localparam int STEP_W = $clog2(STEPS);

  typedef logic [NOTE_W-1:0] note_t;
  typedef logic [STEP_W-1:0] step_t;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    RECORD,
    CLEAR
  } sched_state_t;

endpackage : sequencer_pkg

// File: rtl/sequencer_scheduler_step_gate_timer.sv
// -----------------------------------------------------------------------------
// step_gate_timer
//   Gate-length counter for a pattern step. A load sets the count to TICKS,
//   otherwise it counts down once per clock and saturates at zero.
//   Ports:
//     clk, n_rst : clock, asynchronous active-low reset
//     load       : restart the gate at TICKS
//     clr        : force the gate closed (wins over load)
//     active     : gate is open (count nonzero)
// -----------------------------------------------------------------------------
module step_gate_timer #(
  parameter int TICKS = 1500
) (
  input  logic clk,
  input  logic n_rst,
  input  logic load,
  input  logic clr,
  output logic active
);

  localparam int CNT_W = $clog2(TICKS + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = CNT_W'(TICKS);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign active = (cnt_q != '0);

endmodule : step_gate_timer

// File: rtl/sequencer_scheduler.sv
// -----------------------------------------------------------------------------
// sequencer_scheduler
//   Step-pattern controller: stores a STEPS-entry pattern of notes, advances a
//   step pointer on each tempo beat, sounds each stored note for GATE_TICKS
//   clocks, overdubs live keypad notes while recording, and arbitrates the
//   single note output with live notes taking priority over the pattern.
//   Ports:
//     clk, n_rst  : 10 kHz clock, asynchronous active-low reset
//     beat_pulse  : one-cycle tempo tick
//     run         : transport running (level)
//     record      : overdub enable, effective only while running (level)
//     clear       : one-cycle pulse, erase the whole pattern
//     live_note   : current keypad note, 0 = no key
//     note_out    : registered arbitrated note
//     note_src    : 1 = note_out comes from the pattern
//     step        : current step pointer
//     busy        : pattern erase in progress
// -----------------------------------------------------------------------------
module sequencer_scheduler
  import sequencer_pkg::*;
#(
  parameter int GATE_TICKS = 1500
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              beat_pulse,
  input  logic              run,
  input  logic              record,
  input  logic              clear,
  input  logic [NOTE_W-1:0] live_note,
  output logic [NOTE_W-1:0] note_out,
  output logic              note_src,
  output logic [STEP_W-1:0] step,
  output logic              busy
);

  sched_state_t state_q, state_d;
  step_t        step_q, step_d;
  step_t        step_inc;
  step_t        clr_idx_q;
  note_t        pattern_q [STEPS];
  note_t        live_prev_q;
  note_t        note_q, note_d;
  logic         src_q, src_d;

  logic cur_running;
  logic nxt_running;
  logic live_edge;
  logic rec_wr;
  logic gate_load;
  logic gate_clr;
  logic gate_active;

  assign cur_running = (state_q == PLAY) || (state_q == RECORD);
  assign nxt_running = (state_d == PLAY) || (state_d == RECORD);
  assign step_inc    = step_q + step_t'(1);

  // A key press is a transition from silence; holding or sliding between
  // nonzero notes never re-writes the pattern.
  assign live_edge = (live_prev_q == '0) && (live_note != '0);
  assign rec_wr    = (state_q == RECORD) && live_edge;

  // ---------------------------------------------------------------------------
  // Next-state decode. CLEAR runs to completion and ignores all inputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEAR: begin
        if (clr_idx_q == step_t'(STEPS - 1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        if (clear) begin
          state_d = CLEAR;
        end else if (!run) begin
          state_d = IDLE;
        end else if (record) begin
          state_d = RECORD;
        end else begin
          state_d = PLAY;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Step pointer and gate control. The gate is keyed off the transition so that
  // entering a running state or landing on a new step loads it on the same edge
  // the state/step changes, and dropping out of running closes it at once.
  // ---------------------------------------------------------------------------
  always_comb begin
    step_d    = step_q;
    gate_load = 1'b0;
    gate_clr  = 1'b0;
    if (state_d == CLEAR) begin
      step_d   = '0;
      gate_clr = 1'b1;
    end else begin
      if (cur_running && beat_pulse) begin
        step_d = step_inc;
      end
      if (!nxt_running) begin
        gate_clr = 1'b1;
      end else if (state_q == IDLE) begin
        gate_load = (pattern_q[step_q] != '0);
      end else if (beat_pulse) begin
        // A beat always retriggers: silent steps cut a still-ringing gate.
        gate_load = (pattern_q[step_inc] != '0);
        gate_clr  = !gate_load;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output arbitration: live key first, then an open pattern gate, else silence.
  // ---------------------------------------------------------------------------
  always_comb begin
    note_d = '0;
    src_d  = 1'b0;
    if ((state_q != CLEAR) && (live_note != '0)) begin
      note_d = live_note;
    end else if (cur_running && gate_active) begin
      note_d = pattern_q[step_q];
      src_d  = 1'b1;
    end
  end

  step_gate_timer #(
    .TICKS (GATE_TICKS)
  ) u_gate (
    .clk    (clk),
    .n_rst  (n_rst),
    .load   (gate_load),
    .clr    (gate_clr),
    .active (gate_active)
  );

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      clr_idx_q   <= '0;
      live_prev_q <= '0;
      note_q      <= '0;
      src_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      clr_idx_q   <= (state_q == CLEAR) ? clr_idx_q + step_t'(1) : '0;
      live_prev_q <= (state_q == CLEAR) ? note_t'(0) : live_note;
      note_q      <= note_d;
      src_q       <= src_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pattern storage. The erase walks one entry per cycle; overdub writes land
  // on the pre-increment step even when a beat arrives on the same cycle.
  // ---------------------------------------------------------------------------
  // NOTE: the pattern is reset because a freshly powered sequencer must play
  // silence; a plain data RAM with no such requirement would be left unreset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < STEPS; i++) begin
        pattern_q[i] <= '0;
      end
    end else if (state_q == CLEAR) begin
      pattern_q[clr_idx_q] <= '0;
    end else if (rec_wr) begin
      pattern_q[step_q] <= live_note;
    end
  end

  assign note_out = note_q;
  assign note_src = src_q;
  assign step     = step_q;
  assign busy     = (state_q == CLEAR);

endmodule : sequencer_scheduler

// File: tb/tb_sequencer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sequencer_scheduler
//   Self-checking bench: a cycle model of the scheduler pushes the expected
//   post-edge outputs when each cycle's stimulus is driven; they are popped and
//   compared after the edge. Directed checks cover the key scenarios.
// -----------------------------------------------------------------------------
module tb_sequencer_scheduler;
  import sequencer_pkg::*;

  localparam int GT = 4;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic              src;
    logic [STEP_W-1:0] step;
    logic              busy;
  } obs_t;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              beat_pulse;
  logic              run;
  logic              record;
  logic              clear;
  logic [NOTE_W-1:0] live_note;
  logic [NOTE_W-1:0] note_out;
  logic              note_src;
  logic [STEP_W-1:0] step;
  logic              busy;

  always #5 clk = ~clk;

  sequencer_scheduler #(
    .GATE_TICKS (GT)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .beat_pulse (beat_pulse),
    .run        (run),
    .record     (record),
    .clear      (clear),
    .live_note  (live_note),
    .note_out   (note_out),
    .note_src   (note_src),
    .step       (step),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  sched_state_t m_state;
  int           m_step, m_gate, m_prev, m_note, m_src, m_cidx;
  int           m_pat [STEPS];
  obs_t         exp_q [$];

  task automatic model_reset();
    m_state = IDLE;
    m_step = 0; m_gate = 0; m_prev = 0; m_note = 0; m_src = 0; m_cidx = 0;
    for (int i = 0; i < STEPS; i++) m_pat[i] = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    sched_state_t ns;
    int   nstep, ngate, live;
    bit   running;
    obs_t e;
    live    = int'(live_note);
    running = (m_state == PLAY) || (m_state == RECORD);

    if (m_state == CLEAR) ns = (m_cidx == STEPS - 1) ? IDLE : CLEAR;
    else if (clear)       ns = CLEAR;
    else if (!run)        ns = IDLE;
    else                  ns = record ? RECORD : PLAY;

    // Output from present state (registered, one cycle latency).
    if (m_state != CLEAR && live != 0) begin
      m_note = live; m_src = 0;
    end else if (running && m_gate != 0) begin
      m_note = m_pat[m_step]; m_src = 1;
    end else begin
      m_note = 0; m_src = 0;
    end

    if (ns == CLEAR)                nstep = 0;
    else if (running && beat_pulse) nstep = (m_step + 1) % STEPS;
    else                            nstep = m_step;

    if (ns == CLEAR || ns == IDLE)  ngate = 0;
    else if (m_state == IDLE)       ngate = (m_pat[m_step] != 0) ? GT : 0;
    else if (beat_pulse)            ngate = (m_pat[(m_step + 1) % STEPS] != 0) ? GT : 0;
    else                            ngate = (m_gate > 0) ? m_gate - 1 : 0;

    if (m_state == CLEAR) m_pat[m_cidx] = 0;
    else if (m_state == RECORD && m_prev == 0 && live != 0) m_pat[m_step] = live;

    m_cidx  = (m_state == CLEAR) ? m_cidx + 1 : 0;
    m_prev  = (m_state == CLEAR) ? 0 : live;
    m_state = ns;
    m_step  = nstep;
    m_gate  = ngate;

    e.note = NOTE_W'(m_note);
    e.src  = (m_src != 0);
    e.step = STEP_W'(m_step);
    e.busy = (m_state == CLEAR);
    exp_q.push_back(e);
  endtask

  // One clock: push expectation, take the edge, compare away from the edge.
  task automatic tick();
    obs_t e;
    model_step();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("sb_note", 32'(note_out), 32'(e.note));
    check("sb_src",  32'(note_src), 32'(e.src));
    check("sb_step", 32'(step),     32'(e.step));
    check("sb_busy", 32'(busy),     32'(e.busy));
  endtask

  task automatic cyc(input logic b, input logic r, input logic rc, input logic c,
                     input logic [NOTE_W-1:0] l);
    beat_pulse = b; run = r; record = rc; clear = c; live_note = l;
    tick();
  endtask

  task automatic beats(input int n, input logic rc);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b1, rc, 1'b0, '0);
      cyc(1'b0, 1'b1, rc, 1'b0, '0);
    end
  endtask

  initial begin
    int exp_step;
    n_rst = 1'b0; beat_pulse = 1'b0; run = 1'b0; record = 1'b0; clear = 1'b0; live_note = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_note", 32'(note_out), 32'd0);
    check("rst_src",  32'(note_src), 32'd0);
    check("rst_step", 32'(step),     32'd0);
    check("rst_busy", 32'(busy),     32'd0);
    n_rst = 1'b1;

    // Overdub 7 into step 1, then lap back to step 0 without writing.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd7);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
    beats(7, 1'b1);
    check("lap_step0", 32'(step), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // One beat onto step 1: pattern note 7 for exactly GT cycles.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
    check("gate_step", 32'(step), 32'd1);
    for (int i = 0; i < GT; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
      check("gate_note", 32'(note_out), 32'd7);
      check("gate_src",  32'(note_src), 32'd1);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("gate_end_note", 32'(note_out), 32'd0);
    check("gate_end_src",  32'(note_src), 32'd0);

    // Eight beats walk the pointer all the way round.
    exp_step = 1;
    for (int i = 0; i < STEPS; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
      exp_step = (exp_step + 1) % STEPS;
      check("wrap_step", 32'(step), 32'(exp_step));
      cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    end

    // Key edge coinciding with a beat writes the pre-increment step.
    beats(1, 1'b1);
    check("rec_at2", 32'(step), 32'd2);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd9);
    check("rec_step", 32'(step), 32'd3);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    beats(7, 1'b0);
    check("lap_note9", 32'(note_out), 32'd9);
    check("lap_src9",  32'(note_src), 32'd1);

    // Live key overrides an open gate; release reveals the pattern again.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd5);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
    beats(STEPS, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
    check("live_note", 32'(note_out), 32'd4);
    check("live_src",  32'(note_src), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("rel_note", 32'(note_out), 32'd5);
    check("rel_src",  32'(note_src), 32'd1);

    // Stop, then restart on a nonzero step: the gate loads on entry.
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("entry_note", 32'(note_out), 32'd5);
    check("entry_step", 32'(step),     32'd2);

    // Clear during PLAY: STEPS busy cycles ignoring every input.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, '0);
    check("clr_busy", 32'(busy), 32'd1);
    check("clr_step", 32'(step), 32'd0);
    for (int i = 0; i < STEPS - 1; i++) begin
      cyc(1'b1, 1'b1, 1'b1, (i == 3), NOTE_W'(i + 1));
      check("clr_busy", 32'(busy),     32'd1);
      check("clr_step", 32'(step),     32'd0);
      check("clr_note", 32'(note_out), 32'd0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("clr_done_busy", 32'(busy), 32'd0);
    check("clr_done_step", 32'(step), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < STEPS; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
      check("erased_note", 32'(note_out), 32'd0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
      check("erased_note", 32'(note_out), 32'd0);
    end

    // Reset in the middle of RECORD with pattern {3,0,5,...}.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd3);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
    beats(2, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd5);
    check("pre_rst_note", 32'(note_out), 32'd5);
    n_rst = 1'b0;
    #2;
    check("mid_rst_note", 32'(note_out), 32'd0);
    check("mid_rst_src",  32'(note_src), 32'd0);
    check("mid_rst_step", 32'(step),     32'd0);
    check("mid_rst_busy", 32'(busy),     32'd0);
    model_reset();
    beat_pulse = 1'b0; run = 1'b0; record = 1'b0; clear = 1'b0; live_note = '0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < STEPS; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
      check("post_rst_note", 32'(note_out), 32'd0);
    end

    // Random traffic against the model; beats avoid run edges and clears.
    for (int k = 0; k < 600; k++) begin
      logic              b, r, rc, c;
      logic [NOTE_W-1:0] l;
      r  = ($urandom_range(0, 24) == 0) ? !run : run;
      rc = ($urandom_range(0, 9) == 0) ? !record : record;
      c  = ($urandom_range(0, 79) == 0);
      b  = ($urandom_range(0, 3) == 0) && (r == run) && !c;
      l  = ($urandom_range(0, 4) == 0) ? NOTE_W'($urandom_range(0, 15)) : live_note;
      if (k == 0) r = 1'b1;
      cyc(b, r, rc, c, l);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_sequencer_scheduler
